uart_tx_arbiter: RTL and testbench

- Shares one UART transmit serializer (CLKS_PER_BIT framing, 8N1) among four byte-stream requesters.
- Round-robin arbitration per byte, with an optional per-requester lock that keeps the grant for multi-byte packets.
- Sequences the serializer's one-cycle start strobe, waits for its done pulse, inserts an optional inter-byte gap, and recovers from a hung serializer with a watchdog.
- Sits between the debug/command sources and the single uart_tx instance beside the uart_rx path.

---
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART serializer among four byte requesters.
// Supports per-requester grant lock, an inter-byte gap and a watchdog against a hung serializer.
`timescale 1ns/1ps

module uart_tx_arbiter #(
   parameter int GAP_CLKS     = 0,
   parameter int TIMEOUT_CLKS = 2604
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic [3:0]  i_Req_Valid,
   input  logic [31:0] i_Req_Byte,
   input  logic [3:0]  i_Req_Lock,
   output logic [3:0]  o_Req_Ready,
   output logic        o_Tx_DV,
   output logic [7:0]  o_Tx_Byte,
   input  logic        i_Tx_Done,
   output logic [1:0]  o_Grant_Id,
   output logic        o_Busy,
   output logic        o_Timeout
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      SEND  = 3'd2,
      WAIT  = 3'd3,
      GAP   = 3'd4
   } state_t;

   localparam logic [11:0] WD_LAST  = 12'(TIMEOUT_CLKS - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CLKS - 1);

   state_t      state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  last_q, last_d;
   logic        lock_q, lock_d;
   logic [11:0] wd_q, wd_d;
   logic [15:0] gap_q, gap_d;
   logic [3:0]  ready_q, ready_d;
   logic        dv_q, dv_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic [1:0]  gid_q, gid_d;
   logic        tmo_q, tmo_d;
   logic        wd_expire_s;
   logic [2:0]  pick_s;

   // Returns {found, index} of the first valid requester after 'last', wrapping mod 4.
   function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] last);
      logic [1:0] cand;
      rr_pick = 3'd0;
      for (int k = 4; k >= 1; k--) begin
         cand = last + 2'(k);
         if (valid[cand]) begin
            rr_pick = {1'b1, cand};
         end
      end
   endfunction

   assign pick_s = rr_pick(i_Req_Valid, last_q);

   // State and registered-output flops.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= IDLE;
         gnt_q     <= 2'd0;
         last_q    <= 2'd3;
         lock_q    <= 1'b0;
         wd_q      <= 12'd0;
         gap_q     <= 16'd0;
         ready_q   <= 4'd0;
         dv_q      <= 1'b0;
         tx_byte_q <= 8'd0;
         gid_q     <= 2'd0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         lock_q    <= lock_d;
         wd_q      <= wd_d;
         gap_q     <= gap_d;
         ready_q   <= ready_d;
         dv_q      <= dv_d;
         tx_byte_q <= tx_byte_d;
         gid_q     <= gid_d;
         tmo_q     <= tmo_d;
      end
   end

   // Next-state, arbitration, lock and counter logic.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      lock_d      = lock_q;
      wd_d        = wd_q;
      gap_d       = gap_q;
      wd_expire_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (lock_q && i_Req_Valid[last_q]) begin
               gnt_d   = last_q;
               state_d = GRANT;
            end else begin
               lock_d = 1'b0;
               if (pick_s[2]) begin
                  gnt_d   = pick_s[1:0];
                  state_d = GRANT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GRANT: begin
            lock_d  = i_Req_Lock[gnt_q];
            last_d  = gnt_q;
            // Watchdog starts at zero in the strobe cycle so the abort lands TIMEOUT_CLKS after it.
            wd_d    = 12'd0;
            state_d = SEND;
         end
         SEND: begin
            wd_d    = wd_q + 12'd1;
            state_d = WAIT;
         end
         WAIT: begin
            if (i_Tx_Done) begin
               gap_d   = 16'd0;
               state_d = (GAP_CLKS > 0) ? GAP : IDLE;
            end else if (wd_q >= WD_LAST) begin
               wd_expire_s = 1'b1;
               lock_d      = 1'b0;
               state_d     = IDLE;
            end else begin
               wd_d = wd_q + 12'd1;
            end
         end
         GAP: begin
            if (gap_q >= GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            lock_d  = 1'b0;
         end
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      ready_d   = 4'd0;
      dv_d      = 1'b0;
      tx_byte_d = tx_byte_q;
      gid_d     = gid_q;
      tmo_d     = wd_expire_s;
      if ((state_q == IDLE) && (state_d == GRANT)) begin
         ready_d = 4'd1 << gnt_d;
      end else begin
         ready_d = 4'd0;
      end
      if (state_q == GRANT) begin
         dv_d      = 1'b1;
         tx_byte_d = i_Req_Byte[{gnt_q, 3'b000} +: 8];
         gid_d     = gnt_q;
      end else begin
         dv_d = 1'b0;
      end
   end

   assign o_Req_Ready = ready_q;
   assign o_Tx_DV     = dv_q;
   assign o_Tx_Byte   = tx_byte_q;
   assign o_Grant_Id  = gid_q;
   assign o_Timeout   = tmo_q;
   assign o_Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive bytes, a monitor checks each strobe.
// A second instance with GAP_CLKS=10 covers the inter-byte gap.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

   logic        clk;
   logic        i_Reset;
   logic [3:0]  req_valid;
   logic [31:0] req_byte;
   logic [3:0]  req_lock;
   logic [3:0]  req_ready;
   logic        tx_dv;
   logic [7:0]  tx_byte;
   logic        tx_done;
   logic [1:0]  grant_id;
   logic        busy;
   logic        tmo;

   logic [3:0]  g_valid;
   logic [31:0] g_byte;
   logic [3:0]  g_lock;
   logic [3:0]  g_ready;
   logic        g_dv;
   logic [7:0]  g_txb;
   logic        g_done;
   logic [1:0]  g_gid;
   logic        g_busy;
   logic        g_tmo;

   uart_tx_arbiter dut (
      .i_Clock(clk), .i_Reset(i_Reset), .i_Req_Valid(req_valid), .i_Req_Byte(req_byte),
      .i_Req_Lock(req_lock), .o_Req_Ready(req_ready), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
      .i_Tx_Done(tx_done), .o_Grant_Id(grant_id), .o_Busy(busy), .o_Timeout(tmo)
   );

   uart_tx_arbiter #(.GAP_CLKS(10), .TIMEOUT_CLKS(2604)) u_gap (
      .i_Clock(clk), .i_Reset(i_Reset), .i_Req_Valid(g_valid), .i_Req_Byte(g_byte),
      .i_Req_Lock(g_lock), .o_Req_Ready(g_ready), .o_Tx_DV(g_dv), .o_Tx_Byte(g_txb),
      .i_Tx_Done(g_done), .o_Grant_Id(g_gid), .o_Busy(g_busy), .o_Timeout(g_tmo)
   );

   typedef struct {
      logic [7:0] b;
      logic [1:0] id;
      int         sp;
   } exp_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         rdy_cyc = 0;
   int         strobe_cyc = 0;
   int         last_evt_cyc = 0;
   int         strobe_cnt = 0;
   int         tmo_exp = 0;
   int         hang_n = 0;
   int         done_dly = 20;
   logic [3:0] rdy_val = 4'd0;
   logic [3:0] mon_prev_rdy = 4'd0;
   logic [3:0] drv_prev_rdy = 4'd0;
   bit         done_prev = 1'b0;
   logic [8:0] rbuf [4][8];
   int         rhead [4];
   int         rcnt [4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic load(input int n, input logic lock, input logic [7:0] b);
      rbuf[n][rcnt[n]] = {lock, b};
      rcnt[n] = rcnt[n] + 1;
   endtask

   task automatic expect_tx(input logic [7:0] b, input logic [1:0] id, input int sp);
      exp_t e;
      e.b  = b;
      e.id = id;
      e.sp = sp;
      sb.push_back(e);
   endtask

   function automatic bit pending();
      for (int n = 0; n < 4; n++) begin
         if (rhead[n] < rcnt[n]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy || pending()) && n < 6000) begin
         @(negedge clk);
         n = n + 1;
      end
      if (n >= 6000) begin
         chk({name, "_idle_bound"}, n, 0);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      i_Reset = 1'b1;
      repeat (2) @(negedge clk);
      i_Reset = 1'b0;
   endtask

   // Requester model: present queue heads, advance one cycle after the accept pulse.
   initial begin
      for (int n = 0; n < 4; n++) begin
         rhead[n] = 0;
         rcnt[n]  = 0;
      end
      req_valid = 4'd0;
      req_byte  = 32'd0;
      req_lock  = 4'd0;
      forever begin
         @(posedge clk);
         #1;
         for (int n = 0; n < 4; n++) begin
            if (drv_prev_rdy[n]) rhead[n] = rhead[n] + 1;
            req_valid[n]        = (rhead[n] < rcnt[n]);
            req_byte[8*n +: 8]  = (rhead[n] < rcnt[n]) ? rbuf[n][rhead[n]][7:0] : 8'd0;
            req_lock[n]         = (rhead[n] < rcnt[n]) ? rbuf[n][rhead[n]][8] : 1'b0;
         end
         drv_prev_rdy = req_ready;
      end
   end

   // Serializer model: done pulse done_dly cycles after each strobe unless told to hang.
   initial begin
      tx_done = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         tx_done = 1'b0;
         if (tx_dv) begin
            if (hang_n > 0) begin
               hang_n = hang_n - 1;
            end else begin
               repeat (done_dly) begin
                  @(posedge clk);
                  #3;
               end
               tx_done = 1'b1;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every strobe and checks pulse shapes and spacing.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (req_ready != 4'd0) begin
         chk("ready_single_pulse", int'(mon_prev_rdy), 0);
         rdy_val = req_ready;
         rdy_cyc = cyc;
      end
      mon_prev_rdy = req_ready;
      if (tx_dv) begin
         strobe_cyc = cyc;
         strobe_cnt = strobe_cnt + 1;
         if (sb.size() == 0) begin
            chk("unexpected_strobe", int'(tx_byte), -1);
         end else begin
            e = sb.pop_front();
            chk("tx_byte", int'(tx_byte), int'(e.b));
            chk("grant_id", int'(grant_id), int'(e.id));
            chk("ready_onehot", int'(rdy_val), int'(4'd1 << e.id));
            chk("ready_to_strobe", cyc - rdy_cyc, 1);
            if (e.sp >= 0) chk("strobe_spacing", cyc - last_evt_cyc, e.sp);
         end
      end
      if (done_prev) chk("busy_fall_after_done", int'(busy), 0);
      done_prev = tx_done && busy;
      if (tx_done && busy) last_evt_cyc = cyc;
      if (tmo) begin
         chk("timeout_expected", int'(tmo_exp > 0), 1);
         chk("timeout_delay", cyc - strobe_cyc, 2604);
         if (tmo_exp > 0) tmo_exp = tmo_exp - 1;
         last_evt_cyc = cyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_bound: simulation did not finish by %0t", $time);
      $fatal(1);
   end

   initial begin
      int x;
      int k;
      int n;
      int d;
      int gb;
      i_Reset = 1'b1;
      g_valid = 4'd0;
      g_byte  = 32'h0000_2211;
      g_lock  = 4'd0;
      g_done  = 1'b0;
      repeat (3) @(negedge clk);
      i_Reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_dv", int'(tx_dv), 0);
      chk("rst_byte", int'(tx_byte), 0);
      chk("rst_gid", int'(grant_id), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_timeout", int'(tmo), 0);

      // Single byte latency
      @(negedge clk);
      x = cyc;
      load(0, 1'b0, 8'h3C);
      expect_tx(8'h3C, 2'd0, -1);
      wait_idle("t1");
      chk("t1_ready_latency", rdy_cyc, x + 2);
      chk("t1_strobe_latency", strobe_cyc, x + 3);

      // Round robin across all four from reset
      apply_reset();
      @(negedge clk);
      load(0, 1'b0, 8'hA0);
      load(0, 1'b0, 8'hA4);
      load(1, 1'b0, 8'hA1);
      load(2, 1'b0, 8'hA2);
      load(3, 1'b0, 8'hA3);
      expect_tx(8'hA0, 2'd0, -1);
      expect_tx(8'hA1, 2'd1, 3);
      expect_tx(8'hA2, 2'd2, 3);
      expect_tx(8'hA3, 2'd3, 3);
      expect_tx(8'hA4, 2'd0, 3);
      wait_idle("t2");

      // Locked packet from requester 1 while 0 and 2 wait
      @(negedge clk);
      load(1, 1'b1, 8'hB1);
      load(1, 1'b1, 8'hB2);
      load(1, 1'b0, 8'hB3);
      load(0, 1'b0, 8'hC0);
      load(2, 1'b0, 8'hC2);
      expect_tx(8'hB1, 2'd1, -1);
      expect_tx(8'hB2, 2'd1, 3);
      expect_tx(8'hB3, 2'd1, 3);
      expect_tx(8'hC2, 2'd2, 3);
      expect_tx(8'hC0, 2'd0, 3);
      wait_idle("t3");

      // Hung serializer: watchdog abort then the next requester
      @(negedge clk);
      hang_n  = 1;
      tmo_exp = 1;
      load(1, 1'b0, 8'hD1);
      load(2, 1'b0, 8'hD2);
      expect_tx(8'hD1, 2'd1, -1);
      expect_tx(8'hD2, 2'd2, 2);
      wait_idle("t4");
      chk("t4_timeout_seen", tmo_exp, 0);

      // Gap instance: 10 busy gap cycles between done and the next accept
      @(negedge clk);
      g_valid = 4'b0011;
      n = 0;
      while (g_ready == 4'd0 && n < 20) begin
         @(negedge clk);
         n = n + 1;
      end
      chk("gap_first_ready", int'(g_ready), 1);
      g_valid = 4'b0010;
      @(negedge clk);
      chk("gap_first_dv", int'(g_dv), 1);
      chk("gap_first_byte", int'(g_txb), 8'h11);
      repeat (4) @(negedge clk);
      g_done = 1'b1;
      d = cyc;
      @(negedge clk);
      g_done = 1'b0;
      n = 0;
      gb = 0;
      while (g_ready == 4'd0 && n < 40) begin
         if (g_busy) gb = gb + 1;
         @(negedge clk);
         n = n + 1;
      end
      chk("gap_second_ready", int'(g_ready), 2);
      chk("gap_ready_delay", cyc - d, 12);
      chk("gap_busy_cycles", gb, 10);
      g_valid = 4'b0000;
      @(negedge clk);
      chk("gap_second_dv", int'(g_dv), 1);
      chk("gap_second_byte", int'(g_txb), 8'h22);
      chk("gap_second_gid", int'(g_gid), 1);
      repeat (2) @(negedge clk);
      g_done = 1'b1;
      @(negedge clk);
      g_done = 1'b0;

      // Reset while waiting on a hung byte, then 0 beats 3
      k = strobe_cnt;
      hang_n = 1;
      load(2, 1'b0, 8'hF2);
      expect_tx(8'hF2, 2'd2, -1);
      n = 0;
      while (strobe_cnt == k && n < 50) begin
         @(negedge clk);
         n = n + 1;
      end
      chk("t6_strobe_seen", strobe_cnt, k + 1);
      repeat (5) @(negedge clk);
      #2;
      i_Reset = 1'b1;
      #1;
      chk("t6_rst_ready", int'(req_ready), 0);
      chk("t6_rst_dv", int'(tx_dv), 0);
      chk("t6_rst_byte", int'(tx_byte), 0);
      chk("t6_rst_gid", int'(grant_id), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_timeout", int'(tmo), 0);
      @(negedge clk);
      i_Reset = 1'b0;
      @(negedge clk);
      load(0, 1'b0, 8'h70);
      load(3, 1'b0, 8'h73);
      expect_tx(8'h70, 2'd0, -1);
      expect_tx(8'h73, 2'd3, 3);
      wait_idle("t6");

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
